// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: states, datapath
// select codes, ALU operation classes and the per-state control word.
package multicycle_main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctl_t;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    // wait_ready marks states whose pc_update/ir_write/done only fire once memory completes.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
        logic       done;
        logic       wait_ready;
        logic       decode;
    } ctl_t;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL, OP_LUI: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.wait_ready = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.decode    = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.wait_ready = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
                c.done       = 1'b1;
                c.wait_ready = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
                c.done       = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
                c.done       = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            S_LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control strobes out.
interface multicycle_main_fsm_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       illegal_instr;
    logic       instr_done;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, illegal_instr, instr_done
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, illegal_instr, instr_done
    );

endinterface

// File: rtl/multicycle_main_fsm_alu_op_decoder.sv
// Turns the FSM's ALU operation class plus instruction fields into the ALU function code.
module alu_op_decoder
    import multicycle_main_fsm_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_ctl_t   alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means sub for R-type; addi reuses that bit as immediate.
                    3'b000:  alu_control = ({op5, funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main sequencer of the multi-cycle RV32I core: state register, next-state logic and
// a registered per-state control word, gated by mem_ready, zero and reset.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
#(
    parameter int USE_MEM_READY = 1
)
(
    input logic                   clk,
    input logic                   reset,
    multicycle_main_fsm_if.master bus
);

    state_t   state;
    state_t   next_state;
    ctl_t     ctl_q;
    ctl_t     ctl;
    logic     ready;
    logic     gate;
    logic     illegal;
    alu_ctl_t alu_control;

    assign ready = (USE_MEM_READY == 0) || bus.mem_ready;

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECR;
                    OP_ITYPE:     next_state = S_EXECI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    OP_LUI:       next_state = S_LUI;
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: next_state = ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BEQ:      next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_LUI:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // The control word for the state being entered is registered alongside the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ctl_q <= state_ctl(S_FETCH);
        end else begin
            state <= next_state;
            ctl_q <= state_ctl(next_state);
        end
    end

    // Reset overrides the held word immediately, so an aborted store drops MemWrite this cycle.
    assign ctl     = reset ? state_ctl(S_FETCH) : ctl_q;
    assign gate    = !ctl.wait_ready || ready;
    assign illegal = !reset && ctl.decode && !op_supported(bus.op);

    alu_op_decoder u_alu_op_decoder (
        .alu_op      (ctl.alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (alu_control)
    );

    assign bus.PCWrite       = !reset && ((ctl.pc_update && gate) || (ctl.branch && bus.zero));
    assign bus.IRWrite       = !reset && ctl.ir_write && gate;
    assign bus.RegWrite      = !reset && ctl.reg_write;
    assign bus.MemWrite      = !reset && ctl.mem_write;
    assign bus.AdrSrc        = ctl.adr_src;
    assign bus.ResultSrc     = ctl.result_src;
    assign bus.ALUSrcA       = ctl.alu_src_a;
    assign bus.ALUSrcB       = ctl.alu_src_b;
    assign bus.ALUControl    = alu_control;
    assign bus.illegal_instr = illegal;
    assign bus.instr_done    = !reset && ((ctl.done && gate) || illegal);

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: per-cycle vector table plus hand-written stall,
// reset-abort and latency sequences, all against hand-computed control words.
module tb_multicycle_main_fsm;

    logic clk;
    logic reset;

    multicycle_main_fsm_if bus ();

    multicycle_main_fsm #(.USE_MEM_READY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] ILL  = 7'b1110011;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite} ResultSrc ALUSrcA ALUSrcB ALUControl {illegal,done}
    localparam logic [15:0] W_RST     = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] W_FETCH   = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] W_FSTALL  = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] W_DEC     = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] W_DEC_ILL = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b11};
    localparam logic [15:0] W_MEMADR  = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] W_MEMRD   = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] W_MEMWB   = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b01};
    localparam logic [15:0] W_MEMWR_W = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] W_MEMWR_D = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01};
    localparam logic [15:0] W_EXR_SUB = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00};
    localparam logic [15:0] W_EXR_AND = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00};
    localparam logic [15:0] W_EXI_ADD = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] W_ALUWB   = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01};
    localparam logic [15:0] W_BEQ_T   = {5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b01};
    localparam logic [15:0] W_BEQ_N   = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b01};
    localparam logic [15:0] W_JAL     = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] W_LUI     = {5'b00000, 2'b00, 2'b11, 2'b01, 3'b000, 2'b00};

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        zero;
        logic        mem_ready;
        logic [15:0] want;
    } vec_t;

    vec_t table_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic add(input string name, input logic rst, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic z,
                       input logic rdy, input logic [15:0] want);
        vec_t v;
        v.name = name; v.rst = rst; v.op = op; v.funct3 = f3; v.funct7b5 = f7;
        v.zero = z; v.mem_ready = rdy; v.want = want;
        table_q.push_back(v);
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset         = v.rst;
        bus.op        = v.op;
        bus.funct3    = v.funct3;
        bus.funct7b5  = v.funct7b5;
        bus.zero      = v.zero;
        bus.mem_ready = v.mem_ready;
    endtask

    task automatic check_output(input vec_t v);
        logic [15:0] got;
        got = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
               bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
               bus.illegal_instr, bus.instr_done};
        vectors++;
        if (got !== v.want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b required %b", v.name, got, v.want);
        end
    endtask

    // One clock per vector: drive just after the edge, compare on the falling edge.
    task automatic run_vec(input vec_t v);
        apply_stimulus(v);
        @(negedge clk);
        check_output(v);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string name, input logic rst, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input logic z,
                       input logic rdy, input logic [15:0] want);
        vec_t v;
        v.name = name; v.rst = rst; v.op = op; v.funct3 = f3; v.funct7b5 = f7;
        v.zero = z; v.mem_ready = rdy; v.want = want;
        run_vec(v);
    endtask

    task automatic measure_latency(input string name, input logic [6:0] op, input int want);
        int cycles = 0;
        bit seen   = 1'b0;
        reset = 1'b0; bus.op = op; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (bus.instr_done) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!seen || cycles != want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d cycles (done seen=%0d) required %0d", name, cycles, seen, want);
        end
    endtask

    initial begin
        add("rst_c1",      1, LW,  3'b010, 0, 0, 1, W_RST);
        add("rst_c2",      1, LW,  3'b010, 0, 0, 1, W_RST);
        add("lw_fetch",    0, LW,  3'b010, 0, 0, 1, W_FETCH);
        add("lw_decode",   0, LW,  3'b010, 0, 0, 1, W_DEC);
        add("lw_memadr",   0, LW,  3'b010, 0, 0, 1, W_MEMADR);
        add("lw_memread",  0, LW,  3'b010, 0, 0, 1, W_MEMRD);
        add("lw_memwb",    0, LW,  3'b010, 0, 0, 1, W_MEMWB);
        add("sub_fetch",   0, RT,  3'b000, 1, 0, 1, W_FETCH);
        add("sub_decode",  0, RT,  3'b000, 1, 0, 1, W_DEC);
        add("sub_execr",   0, RT,  3'b000, 1, 0, 1, W_EXR_SUB);
        add("sub_aluwb",   0, RT,  3'b000, 1, 0, 1, W_ALUWB);
        add("addi_fetch",  0, IT,  3'b000, 1, 0, 1, W_FETCH);
        add("addi_decode", 0, IT,  3'b000, 1, 0, 1, W_DEC);
        add("addi_execi",  0, IT,  3'b000, 1, 0, 1, W_EXI_ADD);
        add("addi_aluwb",  0, IT,  3'b000, 1, 0, 1, W_ALUWB);
        add("and_fetch",   0, RT,  3'b111, 0, 0, 1, W_FETCH);
        add("and_decode",  0, RT,  3'b111, 0, 0, 1, W_DEC);
        add("and_execr",   0, RT,  3'b111, 0, 0, 1, W_EXR_AND);
        add("and_aluwb",   0, RT,  3'b111, 0, 0, 1, W_ALUWB);
        add("beqt_fetch",  0, BEQ, 3'b000, 0, 1, 1, W_FETCH);
        add("beqt_decode", 0, BEQ, 3'b000, 0, 1, 1, W_DEC);
        add("beqt_beq",    0, BEQ, 3'b000, 0, 1, 1, W_BEQ_T);
        add("beqn_fetch",  0, BEQ, 3'b000, 0, 0, 1, W_FETCH);
        add("beqn_decode", 0, BEQ, 3'b000, 0, 0, 1, W_DEC);
        add("beqn_beq",    0, BEQ, 3'b000, 0, 0, 1, W_BEQ_N);
        add("jal_fetch",   0, JAL, 3'b000, 0, 0, 1, W_FETCH);
        add("jal_decode",  0, JAL, 3'b000, 0, 0, 1, W_DEC);
        add("jal_jal",     0, JAL, 3'b000, 0, 0, 1, W_JAL);
        add("jal_aluwb",   0, JAL, 3'b000, 0, 0, 1, W_ALUWB);
        add("lui_fetch",   0, LUI, 3'b000, 0, 0, 1, W_FETCH);
        add("lui_decode",  0, LUI, 3'b000, 0, 0, 1, W_DEC);
        add("lui_lui",     0, LUI, 3'b000, 0, 0, 1, W_LUI);
        add("lui_aluwb",   0, LUI, 3'b000, 0, 0, 1, W_ALUWB);
        add("ill_fetch",   0, ILL, 3'b000, 0, 0, 1, W_FETCH);
        add("ill_decode",  0, ILL, 3'b000, 0, 0, 1, W_DEC_ILL);

        for (int i = 0; i < table_q.size(); i++) run_vec(table_q[i]);

        $display("[TB] fetch stall and stalled store");
        run("fetch_stall",  0, SW, 3'b010, 0, 0, 0, W_FSTALL);
        run("sw_fetch",     0, SW, 3'b010, 0, 0, 1, W_FETCH);
        run("sw_decode",    0, SW, 3'b010, 0, 0, 1, W_DEC);
        run("sw_memadr",    0, SW, 3'b010, 0, 0, 1, W_MEMADR);
        for (int i = 0; i < 3; i++)
            run($sformatf("sw_wait%0d", i), 0, SW, 3'b010, 0, 0, 0, W_MEMWR_W);
        run("sw_accept",    0, SW, 3'b010, 0, 0, 1, W_MEMWR_D);

        $display("[TB] stalled load");
        run("lws_fetch",    0, LW, 3'b010, 0, 0, 1, W_FETCH);
        run("lws_decode",   0, LW, 3'b010, 0, 0, 1, W_DEC);
        run("lws_memadr",   0, LW, 3'b010, 0, 0, 1, W_MEMADR);
        run("lws_wait",     0, LW, 3'b010, 0, 0, 0, W_MEMRD);
        run("lws_memread",  0, LW, 3'b010, 0, 0, 1, W_MEMRD);
        run("lws_memwb",    0, LW, 3'b010, 0, 0, 1, W_MEMWB);

        $display("[TB] latency");
        measure_latency("lat_lw",  LW,  5);
        measure_latency("lat_sw",  SW,  4);
        measure_latency("lat_beq", BEQ, 3);
        measure_latency("lat_jal", JAL, 4);
        measure_latency("lat_ill", ILL, 2);

        $display("[TB] reset during store");
        run("rsw_fetch",    0, SW, 3'b010, 0, 0, 1, W_FETCH);
        run("rsw_decode",   0, SW, 3'b010, 0, 0, 1, W_DEC);
        run("rsw_memadr",   0, SW, 3'b010, 0, 0, 1, W_MEMADR);
        run("rsw_reset",    1, SW, 3'b010, 0, 0, 0, W_RST);
        run("rsw_refetch",  0, SW, 3'b010, 0, 0, 1, W_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
